// File: rtl/prci_pkg.sv
// Shared types and defaults for the PRCI reset sequencer.
package prci_pkg;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_PLL_WAIT   = 3'd1,
    ST_DDR_HOLD   = 3'd2,
    ST_CALIB_WAIT = 3'd3,
    ST_DBG_REL    = 3'd4,
    ST_RUN        = 3'd5,
    ST_SYS_HOLD   = 3'd6
  } prci_state_t;

  localparam int PRCI_PLL_STABLE_CNT = 64;
  localparam int PRCI_RST_HOLD_CNT   = 16;
  localparam int PRCI_CALIB_TIMEOUT  = 65535;
  localparam int PRCI_CNT_WIDTH      = 20;

  // Returns {ddr_nrst, dbg_nrst, sys_nrst} for a state.
  function automatic logic [2:0] prci_nrst_decode(input prci_state_t s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      ST_CALIB_WAIT: v = 3'b100;
      ST_DBG_REL:    v = 3'b110;
      ST_SYS_HOLD:   v = 3'b110;
      ST_RUN:        v = 3'b111;
      default:       v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/prci_rst_sequencer_sync.sv
// Two-flop synchronizer with synchronous active-low clear.
module prci_sync2 (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/prci_rst_sequencer.sv
// Releases DDR, debug and system resets in order once the PLL is stable,
// and re-enters the sequence on lock loss or on system-only reset requests.
module prci_rst_sequencer
  import prci_pkg::*;
#(
  parameter int PLL_STABLE_CNT = PRCI_PLL_STABLE_CNT,
  parameter int RST_HOLD_CNT   = PRCI_RST_HOLD_CNT,
  parameter int CALIB_TIMEOUT  = PRCI_CALIB_TIMEOUT,
  parameter int CNT_WIDTH      = PRCI_CNT_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_pll_lock,
  input  logic       i_ddr_calib_done,
  input  logic       i_dmireset,
  input  logic       i_sw_sysreset,
  output logic       o_ddr_nrst,
  output logic       o_dbg_nrst,
  output logic       o_sys_nrst,
  output logic       o_calib_timeout,
  output logic [2:0] o_state
);

  localparam logic [CNT_WIDTH-1:0] PLL_LAST   = CNT_WIDTH'(PLL_STABLE_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(RST_HOLD_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] CALIB_LAST = CNT_WIDTH'(CALIB_TIMEOUT - 1);

  prci_state_t          r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_calib_timeout;
  logic                 r_ddr_nrst;
  logic                 r_dbg_nrst;
  logic                 r_sys_nrst;

  prci_state_t          w_nstate;
  logic [CNT_WIDTH-1:0] w_ncnt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_ntmo;
  logic                 w_lock_s;
  logic                 w_calib_s;
  logic                 w_sys_req;
  logic                 w_lock_guarded;

  prci_sync2 u_sync_lock (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_d    (i_pll_lock),
    .o_q    (w_lock_s)
  );

  prci_sync2 u_sync_calib (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_d    (i_ddr_calib_done),
    .o_q    (w_calib_s)
  );

  assign w_sys_req      = i_dmireset | i_sw_sysreset;
  assign w_cnt_inc      = r_cnt + 1'b1;
  assign w_lock_guarded = (r_state >= ST_DDR_HOLD) && (r_state <= ST_SYS_HOLD);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = w_cnt_inc;
    w_ntmo   = r_calib_timeout;
    case (r_state)
      ST_RESET: begin
        w_nstate = ST_PLL_WAIT;
        w_ncnt   = '0;
      end
      ST_PLL_WAIT: begin
        if (!w_lock_s) begin
          w_ncnt = '0;
        end else if (r_cnt == PLL_LAST) begin
          w_nstate = ST_DDR_HOLD;
          w_ncnt   = '0;
        end
      end
      ST_DDR_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_nstate = ST_CALIB_WAIT;
          w_ncnt   = '0;
        end
      end
      ST_CALIB_WAIT: begin
        // A timed-out controller is still handed to the debugger.
        if (w_calib_s) begin
          w_nstate = ST_DBG_REL;
          w_ncnt   = '0;
          w_ntmo   = 1'b0;
        end else if (r_cnt == CALIB_LAST) begin
          w_nstate = ST_DBG_REL;
          w_ncnt   = '0;
          w_ntmo   = 1'b1;
        end
      end
      ST_DBG_REL: begin
        if (r_cnt == HOLD_LAST) begin
          w_nstate = ST_RUN;
          w_ncnt   = '0;
        end
      end
      ST_RUN: begin
        w_ncnt = '0;
        if (w_sys_req) w_nstate = ST_SYS_HOLD;
      end
      ST_SYS_HOLD: begin
        // dmireset level and fresh sw pulses keep the hold window open.
        if (w_sys_req) begin
          w_ncnt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_nstate = ST_RUN;
          w_ncnt   = '0;
        end
      end
      default: begin
        w_nstate = ST_RESET;
        w_ncnt   = '0;
      end
    endcase

    if (w_lock_guarded && !w_lock_s) begin
      w_nstate = ST_PLL_WAIT;
      w_ncnt   = '0;
      w_ntmo   = r_calib_timeout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state         <= ST_RESET;
      r_cnt           <= '0;
      r_calib_timeout <= 1'b0;
      r_ddr_nrst      <= 1'b0;
      r_dbg_nrst      <= 1'b0;
      r_sys_nrst      <= 1'b0;
    end else begin
      r_state         <= w_nstate;
      r_cnt           <= w_ncnt;
      r_calib_timeout <= w_ntmo;
      {r_ddr_nrst, r_dbg_nrst, r_sys_nrst} <= prci_nrst_decode(w_nstate);
    end
  end

  assign o_ddr_nrst      = r_ddr_nrst;
  assign o_dbg_nrst      = r_dbg_nrst;
  assign o_sys_nrst      = r_sys_nrst;
  assign o_calib_timeout = r_calib_timeout;
  assign o_state         = r_state;

endmodule

// File: tb/tb_prci_rst_sequencer.sv
// Directed bench for prci_rst_sequencer with PLL=4, HOLD=3, CALIB=20.
module tb_prci_rst_sequencer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       lock = 1'b0;
  logic       calib = 1'b0;
  logic       dmi = 1'b0;
  logic       sw = 1'b0;
  logic       ddr_nrst, dbg_nrst, sys_nrst, calib_tmo;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  prci_rst_sequencer #(
    .PLL_STABLE_CNT (4),
    .RST_HOLD_CNT   (3),
    .CALIB_TIMEOUT  (20),
    .CNT_WIDTH      (20)
  ) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .i_pll_lock       (lock),
    .i_ddr_calib_done (calib),
    .i_dmireset       (dmi),
    .i_sw_sysreset    (sw),
    .o_ddr_nrst       (ddr_nrst),
    .o_dbg_nrst       (dbg_nrst),
    .o_sys_nrst       (sys_nrst),
    .o_calib_timeout  (calib_tmo),
    .o_state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nrst vector is {ddr, dbg, sys}.
  task automatic chk_out(input string tag, input logic [2:0] nv, input logic [2:0] st);
    chk({tag, "_nrst"}, {29'd0, ddr_nrst, dbg_nrst, sys_nrst}, {29'd0, nv});
    chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
  endtask

  // Edge numbering: edge 0 is the last edge with nrst low.
  task automatic seq_from_reset(input string tag);
    nrst = 1'b0; lock = 1'b1; calib = 1'b0; dmi = 1'b0; sw = 1'b0;
    step(3);
    chk_out({tag, "_rst"}, 3'b000, 3'd0);
    chk({tag, "_rst_tmo"}, {31'd0, calib_tmo}, 32'd0);
    nrst = 1'b1;
    // 1 RESET edge (sync overlaps), 1 more sync edge, 4 lock counts, 3 hold.
    step(8);
    chk_out({tag, "_e8"}, 3'b000, 3'd2);
    step(1);
    chk_out({tag, "_ddr_rel"}, 3'b100, 3'd3);
    step(5);
    calib = 1'b1;
    step(2);
    chk_out({tag, "_calib_sync"}, 3'b100, 3'd3);
    step(1);
    chk_out({tag, "_dbg_rel"}, 3'b110, 3'd4);
    step(2);
    chk_out({tag, "_stagger"}, 3'b110, 3'd4);
    step(1);
    chk_out({tag, "_run"}, 3'b111, 3'd5);
    chk({tag, "_run_tmo"}, {31'd0, calib_tmo}, 32'd0);
  endtask

  initial begin
    seq_from_reset("nom");

    calib = 1'b0;
    step(4);
    chk_out("calib_fall", 3'b111, 3'd5);

    // sw pulse: low 3 cycles, high again 1+HOLD edges after the request.
    sw = 1'b1; step(1); sw = 1'b0;
    chk_out("sw_hold", 3'b110, 3'd6);
    step(2);
    chk_out("sw_hold_end", 3'b110, 3'd6);
    step(1);
    chk_out("sw_run", 3'b111, 3'd5);

    // Second pulse mid-hold restarts the count.
    sw = 1'b1; step(1); sw = 1'b0;
    step(1);
    sw = 1'b1; step(1); sw = 1'b0;
    step(2);
    chk_out("sw_restart_hold", 3'b110, 3'd6);
    step(1);
    chk_out("sw_restart_run", 3'b111, 3'd5);

    // dmireset held 10 edges: system back 10+3 edges after the request.
    dmi = 1'b1;
    step(6);
    chk_out("dmi_mid", 3'b110, 3'd6);
    step(4);
    dmi = 1'b0;
    step(2);
    chk_out("dmi_tail", 3'b110, 3'd6);
    step(1);
    chk_out("dmi_run", 3'b111, 3'd5);

    // Lock loss reaching the FSM on the same edge as a sw pulse in SYS_HOLD.
    sw = 1'b1; step(1); sw = 1'b0;
    lock = 1'b0;
    step(2);
    chk_out("ll_pre", 3'b110, 3'd6);
    sw = 1'b1; step(1); sw = 1'b0;
    chk_out("ll_drop", 3'b000, 3'd1);

    // Relock with calib low: full wait, then timeout after 20 CALIB_WAIT edges.
    lock = 1'b1;
    step(8);
    chk_out("relock_hold", 3'b000, 3'd2);
    step(1);
    chk_out("relock_ddr", 3'b100, 3'd3);
    step(19);
    chk_out("tmo_pre", 3'b100, 3'd3);
    chk("tmo_pre_flag", {31'd0, calib_tmo}, 32'd0);
    step(1);
    chk_out("tmo_dbg", 3'b110, 3'd4);
    chk("tmo_flag", {31'd0, calib_tmo}, 32'd1);
    step(3);
    chk_out("tmo_run", 3'b111, 3'd5);
    chk("tmo_flag_run", {31'd0, calib_tmo}, 32'd1);

    // Reset mid-RUN clears everything on the next edge.
    nrst = 1'b0;
    step(1);
    chk_out("midrst", 3'b000, 3'd0);
    chk("midrst_flag", {31'd0, calib_tmo}, 32'd0);
    seq_from_reset("rep");

    // Lock glitch after 2 locked counts restarts the stability counter.
    nrst = 1'b0; lock = 1'b0; calib = 1'b0;
    step(3);
    nrst = 1'b1;
    step(1);
    lock = 1'b1;
    step(2);
    lock = 1'b0;
    step(3);
    chk_out("glitch_wait", 3'b000, 3'd1);
    step(1);
    lock = 1'b1;
    step(8);
    chk_out("glitch_hold", 3'b000, 3'd2);
    step(1);
    chk_out("glitch_ddr", 3'b100, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
